fetch_unit: RTL and testbench

Instruction fetch stage for the reduced ARM core. Holds the program counter, fetches the instruction at that address over a req/ack instruction-memory handshake, and presents it to decode. Sits directly upstream of `branch_control`: it supplies `currPC`, `opcode` and `imm`, and it loads `nextPC` back into the PC when decode consumes the instruction.

---
 rtl/core_pkg.sv | 34 +++
 rtl/fetch_unit.sv | 112 +++++++++++
 tb/tb_fetch_unit.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// core_pkg
// Declarations shared by the fetch stage and branch_control: the fetch FSM
// state encoding, the reset PC default, the instruction field positions and
// the opcode constants that both blocks decode.
// Revision: 1.0 - initial release
// ============================================================================
package core_pkg;

  // Fetch FSM states: no request / request outstanding / instruction held.
  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_HOLD = 2'd2
  } fetch_state_e;

  localparam int unsigned C_RESET_PC = 0;

  // The opcode occupies the top OP_BITS of the instruction word, so its
  // position is expressed as an offset from the MSB.
  localparam int unsigned C_OPCODE_MSB_OFFSET = 0;

  // The immediate is always the low half-word.
  localparam int unsigned C_IMM_LSB   = 0;
  localparam int unsigned C_IMM_WIDTH = 16;

  // Opcodes that branch_control also decodes.
  localparam logic [4:0] C_OP_HALT = 5'b11111;
  localparam logic [4:0] C_OP_BR   = 5'b01101;
  localparam logic [4:0] C_OP_JMP  = 5'b00100;

endpackage : core_pkg
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit
// Instruction fetch stage. Holds the PC, fetches the word at that address
// over a req/ack memory handshake and presents it to decode. It loads nextPC
// into the PC when decode consumes the instruction.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   run          lets fetching start out of IDLE; it is sampled only in IDLE
//   nextPC       next PC from branch_control, sampled together with advance
//   advance      decode consumes the held instruction
//   imem_req     memory request, high while in REQ
//   imem_addr    request address, equal to currPC
//   imem_ack     memory returns imem_rdata this cycle
//   imem_rdata   instruction word
//   currPC       current PC
//   instr        registered instruction
//   instr_valid  instr holds the word fetched from currPC
//   opcode, imm  field slices of instr
// Revision: 1.0 - initial release
// ============================================================================
module fetch_unit
  import core_pkg::*;
#(
  parameter int unsigned     BITS       = 16,
  parameter int unsigned     OP_BITS    = 5,
  parameter int unsigned     INSTR_BITS = 32,
  parameter logic [BITS-1:0] RESET_PC   = BITS'(C_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic [BITS-1:0]       nextPC,
  input  logic                  advance,
  output logic                  imem_req,
  output logic [BITS-1:0]       imem_addr,
  input  logic                  imem_ack,
  input  logic [INSTR_BITS-1:0] imem_rdata,
  output logic [BITS-1:0]       currPC,
  output logic [INSTR_BITS-1:0] instr,
  output logic                  instr_valid,
  output logic [OP_BITS-1:0]    opcode,
  output logic [15:0]           imm
);

  fetch_state_e          state_q, state_d;
  logic [BITS-1:0]       pc_q, pc_d;
  logic [INSTR_BITS-1:0] instr_q, instr_d;
  logic                  valid_q, valid_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  // imem_ack only matters in REQ and advance only in HOLD, so each input is
  // looked at only in its own state branch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    case (state_q)
      FETCH_IDLE: begin
        if (run) begin
          state_d = FETCH_REQ;
        end
      end
      FETCH_REQ: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          state_d = FETCH_HOLD;
        end
      end
      FETCH_HOLD: begin
        if (advance) begin
          // nextPC is taken as is; wrap-around is branch_control's business.
          pc_d    = nextPC;
          valid_d = 1'b0;
          state_d = FETCH_REQ;
        end
      end
      default: begin
        state_d = FETCH_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // Decoded straight from the state register so that an asynchronous reset
  // drops the request at once.
  assign imem_req    = (state_q == FETCH_REQ);
  assign imem_addr   = pc_q;
  assign currPC      = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign opcode      = instr_q[INSTR_BITS-1-C_OPCODE_MSB_OFFSET -: OP_BITS];
  assign imm         = instr_q[C_IMM_LSB +: C_IMM_WIDTH];

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_fetch_unit
// Directed-vector bench for fetch_unit: reset, zero-wait and wait-state
// fetches, advance, back-pressure, back-to-back fetching with PC wrap, and
// reset asserted in the middle of a request.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [15:0] nextPC;
  logic        advance;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [15:0] currPC;
  logic [31:0] instr;
  logic        instr_valid;
  logic [4:0]  opcode;
  logic [15:0] imm;

  int total = 0;
  int bad   = 0;

  fetch_unit #(
    .BITS      (16),
    .OP_BITS   (5),
    .INSTR_BITS(32),
    .RESET_PC  (16'h0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .nextPC     (nextPC),
    .advance    (advance),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .currPC     (currPC),
    .instr      (instr),
    .instr_valid(instr_valid),
    .opcode     (opcode),
    .imm        (imm)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs are driven and
  // outputs sampled at that point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; advance = 1'b0; nextPC = '0;
    imem_ack = 1'b0; imem_rdata = '0;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (currPC !== 16'h0000) begin
        bad++; $display("FAIL reset_pc cyc%0d: got %h want 0000", i, currPC);
      end
      total++;
      if (imem_req !== 1'b0) begin
        bad++; $display("FAIL reset_req cyc%0d: got %b want 0", i, imem_req);
      end
      total++;
      if (instr_valid !== 1'b0) begin
        bad++; $display("FAIL reset_valid cyc%0d: got %b want 0", i, instr_valid);
      end
    end
  endtask

  task automatic test_zero_wait();
    run = 1'b1;
    tick();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      bad++; $display("FAIL zw_req: got req=%b addr=%h want 1/0000", imem_req, imem_addr);
    end
    imem_ack = 1'b1; imem_rdata = 32'hA5A5_0003;
    tick();
    imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    total++;
    if (instr_valid !== 1'b1) begin
      bad++; $display("FAIL zw_valid: got %b want 1", instr_valid);
    end
    total++;
    if (opcode !== 5'b10100) begin
      bad++; $display("FAIL zw_opcode: got %b want 10100", opcode);
    end
    total++;
    if (imm !== 16'h0003) begin
      bad++; $display("FAIL zw_imm: got %h want 0003", imm);
    end
    total++;
    if (imem_req !== 1'b0) begin
      bad++; $display("FAIL zw_req_hold: got %b want 0", imem_req);
    end
    // Go back to address 0 for the wait-state fetch.
    advance = 1'b1; nextPC = 16'h0000;
    tick();
    advance = 1'b0;
  endtask

  task automatic test_wait_states();
    // Three cycles without ack, ack on the fourth REQ cycle.
    for (int i = 0; i < 4; i++) begin
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 16'h0000 || instr_valid !== 1'b0) begin
        bad++;
        $display("FAIL ws_req cyc%0d: got req=%b addr=%h valid=%b want 1/0000/0",
                 i, imem_req, imem_addr, instr_valid);
      end
      if (i == 3) begin
        imem_ack = 1'b1; imem_rdata = 32'h6800_1234;
      end
      tick();
    end
    imem_ack = 1'b0;
    total++;
    if (instr_valid !== 1'b1 || instr !== 32'h6800_1234) begin
      bad++; $display("FAIL ws_data: got valid=%b instr=%h want 1/68001234", instr_valid, instr);
    end
    total++;
    if (opcode !== 5'b01101 || imm !== 16'h1234) begin
      bad++; $display("FAIL ws_fields: got op=%b imm=%h want 01101/1234", opcode, imm);
    end
  endtask

  task automatic test_advance();
    advance = 1'b1; nextPC = 16'h0010;
    tick();
    advance = 1'b0; nextPC = 16'h0000;
    total++;
    if (currPC !== 16'h0010 || instr_valid !== 1'b0) begin
      bad++; $display("FAIL adv_pc: got pc=%h valid=%b want 0010/0", currPC, instr_valid);
    end
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0010) begin
      bad++; $display("FAIL adv_req: got req=%b addr=%h want 1/0010", imem_req, imem_addr);
    end
    imem_ack = 1'b1; imem_rdata = 32'h2000_00AB;
    tick();
    imem_ack = 1'b0;
    total++;
    if (instr_valid !== 1'b1 || opcode !== 5'b00100 || imm !== 16'h00AB) begin
      bad++; $display("FAIL adv_fetch: got valid=%b op=%b imm=%h want 1/00100/00ab",
                      instr_valid, opcode, imm);
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 6; i++) begin
      imem_ack   = i[0];
      imem_rdata = 32'h1111_1111 * (i + 3);
      nextPC     = 16'h7777;
      tick();
      total++;
      if (instr !== 32'h2000_00AB || currPC !== 16'h0010) begin
        bad++; $display("FAIL bp_hold cyc%0d: got instr=%h pc=%h want 200000ab/0010",
                        i, instr, currPC);
      end
      total++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b1) begin
        bad++; $display("FAIL bp_req cyc%0d: got req=%b valid=%b want 0/1",
                        i, imem_req, instr_valid);
      end
    end
    imem_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_pc;
    exp_pc  = 16'hFFFE;
    advance = 1'b1; nextPC = exp_pc;
    tick();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin
        bad++; $display("FAIL b2b_req it%0d: got req=%b addr=%h want 1/%h",
                        i, imem_req, imem_addr, exp_pc);
      end
      if (i == 0) begin
        // One wait state with advance high: the PC must not move in REQ.
        nextPC = 16'h5555;
        tick();
        total++;
        if (imem_addr !== exp_pc || imem_req !== 1'b1) begin
          bad++; $display("FAIL b2b_adv_in_req: got addr=%h req=%b want %h/1",
                          imem_addr, imem_req, exp_pc);
        end
      end
      imem_ack = 1'b1; imem_rdata = {16'hC0DE, 16'(i)};
      nextPC   = exp_pc + 16'd4;
      tick();
      imem_ack = 1'b0;
      total++;
      if (instr_valid !== 1'b1 || instr !== {16'hC0DE, 16'(i)} || currPC !== exp_pc) begin
        bad++; $display("FAIL b2b_hold it%0d: got valid=%b instr=%h pc=%h want 1/%h/%h",
                        i, instr_valid, instr, currPC, {16'hC0DE, 16'(i)}, exp_pc);
      end
      exp_pc = exp_pc + 16'd4;
      tick();
    end
    advance = 1'b0;
    // Wrapped past 16'hFFFF: FFFE -> 0002 -> 0006 -> 000A.
    total++;
    if (imem_req !== 1'b1 || currPC !== 16'h000A) begin
      bad++; $display("FAIL b2b_wrap: got req=%b pc=%h want 1/000a", imem_req, currPC);
    end
  endtask

  task automatic test_reset_mid_req();
    run = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (imem_req !== 1'b0 || currPC !== 16'h0000 || instr_valid !== 1'b0) begin
      bad++; $display("FAIL rst_async: got req=%b pc=%h valid=%b want 0/0000/0",
                      imem_req, currPC, instr_valid);
    end
    tick();
    rst = 1'b0;
    // Late ack while idle must be ignored.
    imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    tick(); tick();
    total++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0) begin
      bad++; $display("FAIL rst_late_ack: got req=%b valid=%b instr=%h want 0/0/00000000",
                      imem_req, instr_valid, instr);
    end
    imem_ack = 1'b0; run = 1'b1;
    tick();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      bad++; $display("FAIL rst_restart: got req=%b addr=%h want 1/0000", imem_req, imem_addr);
    end
    imem_ack = 1'b1; imem_rdata = 32'hF800_0042;
    tick();
    imem_ack = 1'b0;
    total++;
    if (instr_valid !== 1'b1 || opcode !== 5'b11111 || imm !== 16'h0042 || currPC !== 16'h0000) begin
      bad++; $display("FAIL rst_refetch: got valid=%b op=%b imm=%h pc=%h want 1/11111/0042/0000",
                      instr_valid, opcode, imm, currPC);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_advance();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_req();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fetch_unit
`default_nettype wire
